// File: rtl/counter_mode_ctrl.sv
// Run/pause/done controller for a selectable 2-digit / 3-digit counter pair.
// Issues one-clk count enables and clears to the selected counter; every output is registered.
module counter_mode_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       count_tick,
  input  logic       start_pulse,
  input  logic       mode_pulse,
  input  logic       stop_in,
  output logic       counter_sel,
  output logic       en_2d,
  output logic       en_3d,
  output logic       clr_2d,
  output logic       clr_3d,
  output logic [1:0] run_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    DONE  = 2'b11
  } state_t;

  state_t state_reg, state_next;
  logic   sel_reg, sel_next;
  logic   en_2d_reg, en_2d_next;
  logic   en_3d_reg, en_3d_next;
  logic   clr_2d_reg, clr_2d_next;
  logic   clr_3d_reg, clr_3d_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      sel_reg    <= 1'b0;
      en_2d_reg  <= 1'b0;
      en_3d_reg  <= 1'b0;
      clr_2d_reg <= 1'b0;
      clr_3d_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      sel_reg    <= sel_next;
      en_2d_reg  <= en_2d_next;
      en_3d_reg  <= en_3d_next;
      clr_2d_reg <= clr_2d_next;
      clr_3d_reg <= clr_3d_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    sel_next    = sel_reg;
    en_2d_next  = 1'b0;
    en_3d_next  = 1'b0;
    clr_2d_next = 1'b0;
    clr_3d_next = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (start_pulse) begin
          state_next = RUN;
        end else if (mode_pulse) begin
          sel_next    = ~sel_reg;
          clr_2d_next = sel_reg;
          clr_3d_next = ~sel_reg;
        end
      end
      RUN: begin
        // Terminal count outranks pause; a tick on a leaving cycle is dropped.
        if (stop_in) begin
          state_next = DONE;
        end else if (start_pulse) begin
          state_next = PAUSE;
        end else if (count_tick) begin
          en_2d_next = ~sel_reg;
          en_3d_next = sel_reg;
        end
      end
      PAUSE: begin
        if (start_pulse) state_next = RUN;
      end
      DONE: begin
        if (start_pulse) begin
          state_next  = IDLE;
          clr_2d_next = ~sel_reg;
          clr_3d_next = sel_reg;
        end else if (mode_pulse) begin
          state_next  = IDLE;
          sel_next    = ~sel_reg;
          clr_2d_next = sel_reg;
          clr_3d_next = ~sel_reg;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign counter_sel = sel_reg;
  assign en_2d       = en_2d_reg;
  assign en_3d       = en_3d_reg;
  assign clr_2d      = clr_2d_reg;
  assign clr_3d      = clr_3d_reg;
  assign run_state   = state_reg;

endmodule
